// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: opcodes, ALU/source encodings,
// FSM states and instruction-field offsets.
package cpu_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_SET  = 3'd2;
  localparam logic [2:0] OP_COPY = 3'd3;
  localparam logic [2:0] OP_ADDR = 3'd4;
  localparam logic [2:0] OP_ADDV = 3'd5;
  localparam logic [2:0] OP_SUBR = 3'd6;
  localparam logic [2:0] OP_SUBV = 3'd7;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_REG = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_FAULT
  } state_e;

  // Instruction word layout, LSB first: imm, rs, rd, op.
  localparam int IMM_LSB = 0;

  function automatic int rs_lsb(input int w);
    return w;
  endfunction

  function automatic int rd_lsb(input int w, input int rw);
    return w + rw;
  endfunction

  function automatic int op_lsb(input int w, input int rw);
    return w + 2 * rw;
  endfunction

endpackage

// File: rtl/cpu_sequencer_pc_counter.sv
// Program counter: aw-bit register with increment and asynchronous clear.
module pc_counter #(
  parameter int aw = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  output logic [aw-1:0] pc
);

  logic [aw-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = inc ? pc_q + aw'(1) : pc_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetches over req/ack, decodes, and drives the
// register-file strobes and ALU/operand controls for the 8-bit datapath.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int w        = 8,
  parameter int op_w     = 3,
  parameter int alu_op_w = 1,
  parameter int aw       = 8,
  parameter int rw       = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     imem_req,
  output logic [aw-1:0]            imem_addr,
  input  logic                     imem_ack,
  input  logic [op_w+2*rw+w-1:0]   imem_data,
  output logic [rw-1:0]            rf_raddr_a,
  output logic [rw-1:0]            rf_raddr_b,
  output logic [rw-1:0]            rf_waddr,
  output logic                     rf_we,
  output logic [1:0]               src_sel,
  output logic                     b_sel,
  output logic [alu_op_w-1:0]      alu_op,
  output logic [w-1:0]             imm,
  output logic [aw-1:0]            pc,
  output logic                     halted,
  output logic                     fault
);

  localparam int IW     = op_w + 2 * rw + w;
  localparam int RS_LSB = rs_lsb(w);
  localparam int RD_LSB = rd_lsb(w, rw);
  localparam int OP_LSB = op_lsb(w, rw);

  state_e                state_q, state_d;
  logic [IW-1:0]         ir_q, ir_d;
  logic                  imem_req_q, imem_req_d;
  logic                  rf_we_q, rf_we_d;
  logic [1:0]            src_sel_q, src_sel_d;
  logic                  b_sel_q, b_sel_d;
  logic [alu_op_w-1:0]   alu_op_q, alu_op_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic                  pc_inc;
  logic [op_w-1:0]       op_f, op_ir;

  assign op_f  = imem_data[OP_LSB +: op_w];
  assign op_ir = ir_q[OP_LSB +: op_w];

  pc_counter #(.aw(aw)) u_pc (
    .clock (clock),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    src_sel_d = src_sel_q;
    b_sel_d   = b_sel_q;
    alu_op_d  = alu_op_q;
    pc_inc    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          // Controls are decoded from the incoming word so they are already
          // registered and stable by the first DECODE cycle.
          pc_inc   = 1'b1;
          ir_d     = imem_data;
          alu_op_d = alu_op_w'(op_f[1]);
          b_sel_d  = (op_f == op_w'(OP_ADDV)) || (op_f == op_w'(OP_SUBV));
          case (op_f)
            op_w'(OP_SET):  src_sel_d = SRC_IMM;
            op_w'(OP_COPY): src_sel_d = SRC_REG;
            default:        src_sel_d = SRC_ALU;
          endcase
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_ir)
          op_w'(OP_NOP):  state_d = S_FETCH;
          op_w'(OP_HALT): state_d = S_HALT;
          op_w'(OP_SET),
          op_w'(OP_COPY): state_d = S_WB;
          op_w'(OP_ADDR),
          op_w'(OP_ADDV),
          op_w'(OP_SUBR),
          op_w'(OP_SUBV): state_d = S_EXEC;
          default:        state_d = S_FAULT;
        endcase
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    imem_req_d = (state_d == S_FETCH);
    rf_we_d    = (state_d == S_WB);
    halted_d   = halted_q | (state_d == S_HALT);
    fault_d    = fault_q  | (state_d == S_FAULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      src_sel_q  <= SRC_ALU;
      b_sel_q    <= 1'b0;
      alu_op_q   <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      rf_we_q    <= rf_we_d;
      src_sel_q  <= src_sel_d;
      b_sel_q    <= b_sel_d;
      alu_op_q   <= alu_op_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc;
  assign rf_raddr_a = ir_q[RD_LSB +: rw];
  assign rf_raddr_b = ir_q[RS_LSB +: rw];
  assign rf_waddr   = ir_q[RD_LSB +: rw];
  assign imm        = ir_q[IMM_LSB +: w];
  assign rf_we      = rf_we_q;
  assign src_sel    = src_sel_q;
  assign b_sel      = b_sel_q;
  assign alu_op     = alu_op_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
